branchpredictor_sa: RTL and testbench

BRANCHPREDICTOR_SA -- requirements
Module: branchpredictor_sa

---
 rtl/branchpredictor_sa.sv | 208 ++++++++++++++++++++
 tb/tb_branchpredictor_sa.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branchpredictor_sa.sv
// Set-associative branch target predictor with per-way saturating direction counters.
// Define BP_STATS_EN to add the stat_updates / stat_mispredicts counters.
module branchpredictor_sa #(
    parameter int ADDR_SIZE = 32,
    parameter int SET_BITS  = 2,
    parameter int WAYS      = 2,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] current_pc,
    input  logic                 flush,
    input  logic                 feedback_enable,
    input  logic                 feedback_branch_taken,
    input  logic [ADDR_SIZE-1:0] feedback_branch_addr,
    input  logic [ADDR_SIZE-1:0] feedback_current_pc,
    output logic                 opinion,
    output logic                 branch_taken,
    output logic [ADDR_SIZE-1:0] branch_addr
`ifdef BP_STATS_EN
    ,
    output logic [31:0]          stat_updates,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_SIZE - SET_BITS - 2;
    localparam int TGT_W = ADDR_SIZE - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};

    logic [WAYS-1:0]     r_valid  [SETS];
    logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
    logic [TGT_W-1:0]    r_target [SETS][WAYS];
    logic [CTR_BITS-1:0] r_ctr    [SETS][WAYS];

    logic [SET_BITS-1:0] w_lk_set;
    logic [TAG_W-1:0]    w_lk_tag;
    logic                w_lk_hit;
    logic [WAY_W-1:0]    w_lk_way;
    logic [SET_BITS-1:0] w_fb_set;
    logic [TAG_W-1:0]    w_fb_tag;
    logic                w_fb_hit;
    logic [WAY_W-1:0]    w_fb_way;
    logic                w_inv_found;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_ptr_cur;
    logic [WAY_W-1:0]    w_victim;
    logic                w_fb_pred;
    logic                w_unused_lsbs;

    assign w_lk_set      = current_pc[SET_BITS+1:2];
    assign w_lk_tag      = current_pc[ADDR_SIZE-1:SET_BITS+2];
    assign w_fb_set      = feedback_current_pc[SET_BITS+1:2];
    assign w_fb_tag      = feedback_current_pc[ADDR_SIZE-1:SET_BITS+2];
    assign w_victim      = w_inv_found ? w_inv_way : w_ptr_cur;
    assign w_unused_lsbs = ^{current_pc[1:0], feedback_current_pc[1:0], feedback_branch_addr[1:0]};

    function automatic logic [CTR_BITS-1:0] f_ctr_step(input logic [CTR_BITS-1:0] ctr,
                                                       input logic taken);
        logic [CTR_BITS-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            nxt = (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        end else begin
            nxt = (ctr == {CTR_BITS{1'b0}}) ? ctr : ctr - CTR_BITS'(1);
        end
        return nxt;
    endfunction

    // Lookup tag match: first valid way whose tag equals the current pc tag
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!w_lk_hit && r_valid[w_lk_set][i] && (r_tag[w_lk_set][i] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_way = WAY_W'(i);
            end else begin
                w_lk_hit = w_lk_hit;
            end
        end
    end

    // Prediction outputs, forced to zero on a miss
    always_comb begin
        opinion      = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        if (w_lk_hit) begin
            opinion      = 1'b1;
            branch_taken = r_ctr[w_lk_set][w_lk_way][CTR_BITS-1];
            branch_addr  = {r_target[w_lk_set][w_lk_way], 2'b00};
        end else begin
            opinion      = 1'b0;
        end
    end

    // Feedback side: tag hit search plus lowest-index invalid way for allocation
    always_comb begin
        w_fb_hit    = 1'b0;
        w_fb_way    = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!w_fb_hit && r_valid[w_fb_set][i] && (r_tag[w_fb_set][i] == w_fb_tag)) begin
                w_fb_hit = 1'b1;
                w_fb_way = WAY_W'(i);
            end else begin
                w_fb_hit = w_fb_hit;
            end
            if (!w_inv_found && !r_valid[w_fb_set][i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(i);
            end else begin
                w_inv_found = w_inv_found;
            end
        end
        w_fb_pred = w_fb_hit ? r_ctr[w_fb_set][w_fb_way][CTR_BITS-1] : 1'b0;
    end

    // Entry storage: reset/flush invalidate, feedback updates a hit or allocates a victim
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_ctr[s][w]    <= CTR_WEAK_NT;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ctr[s][w] <= CTR_WEAK_NT;
                end
            end
        end else if (feedback_enable) begin
            if (w_fb_hit) begin
                r_target[w_fb_set][w_fb_way] <= feedback_branch_addr[ADDR_SIZE-1:2];
                r_ctr[w_fb_set][w_fb_way]    <= f_ctr_step(r_ctr[w_fb_set][w_fb_way],
                                                           feedback_branch_taken);
            end else begin
                r_valid[w_fb_set][w_victim]  <= 1'b1;
                r_tag[w_fb_set][w_victim]    <= w_fb_tag;
                r_target[w_fb_set][w_victim] <= feedback_branch_addr[ADDR_SIZE-1:2];
                r_ctr[w_fb_set][w_victim]    <= feedback_branch_taken ? CTR_WEAK_T : CTR_WEAK_NT;
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] r_ptr [SETS];

            // Round-robin pointer moves only when an allocation evicts a valid way
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < SETS; s++) begin
                        r_ptr[s] <= '0;
                    end
                end else if (flush) begin
                    for (int s = 0; s < SETS; s++) begin
                        r_ptr[s] <= '0;
                    end
                end else if (feedback_enable && !w_fb_hit && !w_inv_found) begin
                    r_ptr[w_fb_set] <= r_ptr[w_fb_set] + WAY_W'(1);
                end
            end

            assign w_ptr_cur = r_ptr[w_fb_set];
        end else begin : g_dm
            assign w_ptr_cur = '0;
        end
    endgenerate

`ifdef BP_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    // Saturating activity counters over accepted feedback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_updates     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else if (flush) begin
            r_stat_updates     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else if (feedback_enable) begin
            if (r_stat_updates != 32'hFFFF_FFFF) begin
                r_stat_updates <= r_stat_updates + 32'd1;
            end
            if ((w_fb_pred != feedback_branch_taken) && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branchpredictor_sa.sv
// Randomized self-checking bench for branchpredictor_sa against an array-based reference model,
// with directed literal checks for cold lookup, latency, counters, eviction, flush and async reset.
module tb_branchpredictor_sa;
    localparam int AW   = 32;
    localparam int SB   = 2;
    localparam int WAYS = 2;
    localparam int CB   = 2;
    localparam int SETS = 1 << SB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CMID = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] current_pc = 32'h0;
    logic          flush = 1'b0;
    logic          feedback_enable = 1'b0;
    logic          feedback_branch_taken = 1'b0;
    logic [AW-1:0] feedback_branch_addr = 32'h0;
    logic [AW-1:0] feedback_current_pc = 32'h0;
    logic          opinion;
    logic          branch_taken;
    logic [AW-1:0] branch_addr;
`ifdef BP_STATS_EN
    logic [31:0]   stat_updates;
    logic [31:0]   stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branchpredictor_sa #(.ADDR_SIZE(AW), .SET_BITS(SB), .WAYS(WAYS), .CTR_BITS(CB)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .current_pc            (current_pc),
        .flush                 (flush),
        .feedback_enable       (feedback_enable),
        .feedback_branch_taken (feedback_branch_taken),
        .feedback_branch_addr  (feedback_branch_addr),
        .feedback_current_pc   (feedback_current_pc),
        .opinion               (opinion),
        .branch_taken          (branch_taken),
        .branch_addr           (branch_addr)
`ifdef BP_STATS_EN
        ,
        .stat_updates          (stat_updates),
        .stat_mispredicts      (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by set number and way number
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int unsigned m_tgt   [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    int          m_ptr   [SETS];
    longint      m_upd = 0;
    longint      m_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (SB + 2);
    endfunction

    function automatic int find_way(input logic [31:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = CMID - 1;
            end
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int s, w, pred;
        s = set_of(pc);
        w = find_way(pc);
        pred = (w >= 0 && m_ctr[s][w] >= CMID) ? 1 : 0;
        m_upd++;
        if (pred != int'(taken)) m_mis++;
        if (w >= 0) begin
            m_tgt[s][w] = tgt >> 2;
            if (taken) m_ctr[s][w] = (m_ctr[s][w] < CMAX) ? m_ctr[s][w] + 1 : CMAX;
            else       m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
        end else begin
            for (int i = WAYS - 1; i >= 0; i--)
                if (!m_valid[s][i]) w = i;
            if (w < 0) begin
                w = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = tag_of(pc);
            m_tgt[s][w]   = tgt >> 2;
            m_ctr[s][w]   = taken ? CMID : CMID - 1;
        end
    endtask

    // Model state advance, mirroring the clock edge and asynchronous reset
    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else if (flush) model_clear();
        else if (feedback_enable) model_update(feedback_current_pc, feedback_branch_taken, feedback_branch_addr);
    end

    // Per-cycle comparison of lookup outputs against the model
    always @(negedge clk) begin
        int w, s;
        logic [31:0] e_addr;
        bit e_op, e_tk;
        w = find_way(current_pc);
        s = set_of(current_pc);
        e_op = (w >= 0);
        e_tk = (w >= 0) && (m_ctr[s][w] >= CMID);
        e_addr = (w >= 0) ? (m_tgt[s][w] << 2) : 32'h0;
        chk("cyc_opinion", {31'd0, opinion}, {31'd0, e_op});
        chk("cyc_taken", {31'd0, branch_taken}, {31'd0, e_tk});
        chk("cyc_addr", branch_addr, e_addr);
`ifdef BP_STATS_EN
        chk("cyc_stat_updates", stat_updates, m_upd[31:0]);
        chk("cyc_stat_mispredicts", stat_mispredicts, m_mis[31:0]);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fb(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        feedback_enable       = 1'b1;
        feedback_current_pc   = pc;
        feedback_branch_taken = taken;
        feedback_branch_addr  = tgt;
        tick();
        feedback_enable = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit op, input logic [31:0] addr);
        current_pc = pc;
        #1;
        chk({name, "_opinion"}, {31'd0, opinion}, {31'd0, op});
        chk({name, "_addr"}, branch_addr, addr);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t, s, lo;
        t  = $urandom_range(0, 5);
        s  = $urandom_range(0, SETS - 1);
        lo = $urandom_range(0, 3);
        return (t << (SB + 2)) | (s << 2) | lo;
    endfunction

    initial begin
        current_pc = 32'h40;
        #1;
        chk("rst_opinion", {31'd0, opinion}, 32'd0);
        chk("rst_taken", {31'd0, branch_taken}, 32'd0);
        chk("rst_addr", branch_addr, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // First allocation: not visible in the update cycle, visible the next
        feedback_enable       = 1'b1;
        feedback_current_pc   = 32'h40;
        feedback_branch_taken = 1'b1;
        feedback_branch_addr  = 32'h100;
        #1;
        chk("same_cycle_opinion", {31'd0, opinion}, 32'd0);
        tick();
        feedback_enable = 1'b0;
        #1;
        chk("next_cycle_opinion", {31'd0, opinion}, 32'd1);
        chk("next_cycle_taken", {31'd0, branch_taken}, 32'd1);
        chk("next_cycle_addr", branch_addr, 32'h100);

        // Counter walk 2 -> 3 -> 3 -> 2 -> 1
        fb(32'h40, 1'b1, 32'h100);
        fb(32'h40, 1'b1, 32'h100);
        fb(32'h40, 1'b0, 32'h100);
        #1;
        chk("ctr2_taken", {31'd0, branch_taken}, 32'd1);
        fb(32'h40, 1'b0, 32'h100);
        #1;
        chk("ctr1_taken", {31'd0, branch_taken}, 32'd0);
        chk("ctr1_opinion", {31'd0, opinion}, 32'd1);

        // Set-0 fill and round-robin eviction
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fb(32'h40, 1'b1, 32'h200);
        fb(32'h80, 1'b1, 32'h300);
        fb(32'hC0, 1'b1, 32'h400);
        look("evict1_40", 32'h40, 1'b0, 32'h0);
        look("evict1_80", 32'h80, 1'b1, 32'h300);
        look("evict1_c0", 32'hC0, 1'b1, 32'h400);
        fb(32'h100, 1'b1, 32'h500);
        look("evict2_80", 32'h80, 1'b0, 32'h0);
        look("evict2_c0", 32'hC0, 1'b1, 32'h400);
        look("evict2_100", 32'h100, 1'b1, 32'h500);

        // Flush wins over a coincident feedback
        flush = 1'b1;
        fb(32'h44, 1'b1, 32'h700);
        flush = 1'b0;
        look("flush_c0", 32'hC0, 1'b0, 32'h0);
        look("flush_44", 32'h44, 1'b0, 32'h0);
        look("flush_100", 32'h100, 1'b0, 32'h0);

        // Asynchronous reset between clock edges
        fb(32'h40, 1'b1, 32'h600);
        look("pre_rst", 32'h40, 1'b1, 32'h600);
        tick();
        reset = 1'b0;
        #1;
        chk("async_rst_opinion", {31'd0, opinion}, 32'd0);
        chk("async_rst_addr", branch_addr, 32'd0);
        #1;
        reset = 1'b1;

`ifdef BP_STATS_EN
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fb(32'h40, 1'b1, 32'h100);
        fb(32'h40, 1'b1, 32'h100);
        fb(32'h40, 1'b0, 32'h100);
        fb(32'h40, 1'b1, 32'h100);
        #1;
        chk("stat_updates", stat_updates, 32'd4);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        // Randomized traffic over a small address pool to force hits and evictions
        for (int i = 0; i < 3000; i++) begin
            flush                 = ($urandom_range(0, 79) == 0);
            feedback_enable       = ($urandom_range(0, 2) != 0);
            feedback_current_pc   = rand_pc();
            feedback_branch_taken = $urandom_range(0, 1);
            feedback_branch_addr  = $urandom;
            current_pc            = rand_pc();
            tick();
        end
        flush = 1'b0;
        feedback_enable = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
